// File: rtl/imm_gen_pipe_pkg.sv
// rv_imm_pkg: shared types and decode logic for the immediate generator.
//   fmt_e        - instruction format (FMT_NONE is the all-zero encoding so a
//                  cleared record naturally reads as "no format")
//   OP_*         - base opcode constants
//   dec_t        - one decoded instruction; imm is always carried at 64 bits
//                  and narrowed to XLEN by the top level
//   build_dec()  - pure combinational decode of one instruction word
//   skid_state_e - occupancy states of the output skid buffer
package rv_imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_IMM32  = 7'h1B;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_REG32  = 7'h3B;

    localparam int unsigned IMM_W = 64;

    typedef enum logic [1:0] {
        SK_EMPTY,
        SK_ONE,
        SK_FULL
    } skid_state_e;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [4:0]       rd;
        logic [2:0]       funct3;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [6:0]       funct7;
        fmt_e             fmt;
        logic [IMM_W-1:0] imm;
        logic             illegal;
    } dec_t;

    // rv64 enables the *W opcodes (OP_IMM32 / OP_REG32).
    function automatic dec_t build_dec(input logic [31:0] ins, input logic rv64);
        dec_t d;
        fmt_e f;
        d = '0;
        f = FMT_NONE;

        d.opcode = ins[6:0];
        d.rd     = ins[11:7];
        d.funct3 = ins[14:12];
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.funct7 = ins[31:25];

        // Every listed opcode ends in 2'b11, so a compressed-looking word
        // (ins[1:0] != 2'b11) can never match and falls into FMT_NONE.
        case (ins[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: f = FMT_I;
            OP_IMM32:  f = rv64 ? FMT_I : FMT_NONE;
            OP_STORE:  f = FMT_S;
            OP_BRANCH: f = FMT_B;
            OP_LUI, OP_AUIPC: f = FMT_U;
            OP_JAL:    f = FMT_J;
            OP_REG:    f = FMT_R;
            OP_REG32:  f = rv64 ? FMT_R : FMT_NONE;
            default:   f = FMT_NONE;
        endcase

        d.fmt     = f;
        d.illegal = (f == FMT_NONE) || (ins[1:0] != 2'b11);

        case (f)
            FMT_I: d.imm = {{52{ins[31]}}, ins[31:20]};
            FMT_S: d.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B: d.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U: d.imm = {{32{ins[31]}}, ins[31:12], 12'b0};
            FMT_J: d.imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: d.imm = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_skid.sv
// imm_skid_buf: generic valid/ready pipeline buffer carrying a record of type T.
//   SKID=1: two entries (main + skid); in_ready is registered and depends only
//           on occupancy, so the upstream never sees out_ready combinationally.
//   SKID=0: single register; in_ready = !out_valid | out_ready.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake, in_data payload
//   out_valid / out_ready downstream handshake, out_data payload (main entry)
// The output record is cleared on reset and otherwise only changes on a load,
// so it stays stable while out_valid=1 and out_ready=0.
module imm_skid_buf
    import rv_imm_pkg::*;
#(
    parameter type T    = dec_t,
    parameter bit  SKID = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    if (SKID) begin : g_skid
        skid_state_e state, state_nxt;
        T            main_q, skid_q;
        logic        rdy_q;
        logic        in_xfer, out_xfer;
        logic        load_main, main_from_skid, load_skid;

        always_comb begin
            in_xfer        = in_valid && rdy_q;
            out_xfer       = (state != SK_EMPTY) && out_ready;
            state_nxt      = state;
            load_main      = 1'b0;
            main_from_skid = 1'b0;
            load_skid      = 1'b0;
            case (state)
                SK_EMPTY: begin
                    if (in_xfer) begin
                        state_nxt = SK_ONE;
                        load_main = 1'b1;
                    end
                end
                SK_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        state_nxt = SK_FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = SK_EMPTY;
                    end
                end
                SK_FULL: begin
                    // rdy_q is low here, so only the drain side can move.
                    if (out_xfer) begin
                        state_nxt      = SK_ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = SK_EMPTY;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= SK_EMPTY;
                rdy_q  <= 1'b0;
                main_q <= '0;
                skid_q <= '0;
            end else begin
                state <= state_nxt;
                // Registered copy of (state != FULL) for the next cycle.
                rdy_q <= (state_nxt != SK_FULL);
                if (load_main) begin
                    main_q <= main_from_skid ? skid_q : in_data;
                end
                if (load_skid) begin
                    skid_q <= in_data;
                end
            end
        end

        assign in_ready  = rdy_q;
        assign out_valid = (state != SK_EMPTY);
        assign out_data  = main_q;
    end else begin : g_reg
        T     data_q;
        logic valid_q;
        logic alive_q;
        logic in_xfer;

        assign in_xfer = in_valid && in_ready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                alive_q <= 1'b0;
            end else begin
                alive_q <= 1'b1;
                if (in_xfer) begin
                    data_q  <= in_data;
                    valid_q <= 1'b1;
                end else if (out_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end

        // alive_q keeps in_ready low until the first edge after reset.
        assign in_ready  = alive_q && (!valid_q || out_ready);
        assign out_valid = valid_q;
        assign out_data  = data_q;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32/RV64 immediate generator and field splitter.
// Decodes format, register/funct fields and the sign-extended immediate of
// each accepted instruction and presents them one cycle later through an
// output buffer (2-entry skid when SKID=1).
// Parameters: XLEN (32 or 64) immediate width; SKID buffer depth select.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready/ins fetch-side handshake and raw instruction word
//   out_valid/out_ready   register-read-side handshake
//   opcode rd funct3 rs1 rs2 funct7  raw instruction fields
//   fmt                   decoded format (rv_imm_pkg::fmt_e encoding)
//   imm                   sign-extended immediate, 0 for R and NONE formats
//   illegal               unknown opcode or ins[1:0] != 2'b11
module imm_gen_pipe
    import rv_imm_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter bit          SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ins,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    dec_t dec_in;
    dec_t dec_q;

    always_comb begin
        dec_in = build_dec(ins, XLEN == 64);
    end

    imm_skid_buf #(
        .T    (dec_t),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (dec_q)
    );

    assign opcode  = dec_q.opcode;
    assign rd      = dec_q.rd;
    assign funct3  = dec_q.funct3;
    assign rs1     = dec_q.rs1;
    assign rs2     = dec_q.rs2;
    assign funct7  = dec_q.funct7;
    assign fmt     = dec_q.fmt;
    assign illegal = dec_q.illegal;
    // The record always carries a 64-bit sign-extended immediate; for
    // XLEN=32 the low half is already the correct 32-bit value.
    assign imm     = dec_q.imm[XLEN-1:0];

    if (XLEN < IMM_W) begin : g_narrow
        logic unused_imm_hi;
        assign unused_imm_hi = ^dec_q.imm[IMM_W-1:XLEN];
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance (both SKID=1)
// share the same stimulus. A queue-based occupancy model plus an arithmetic
// immediate reference checks every cycle; a vector table and hand-written
// sequences cover the directed cases.
module tb_imm_gen_pipe;
    import rv_imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] ins = '0;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [6:0]  a_opcode, a_funct7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3, a_fmt;
    logic [31:0] a_imm;

    logic        b_in_ready, b_out_valid, b_illegal;
    logic [6:0]  b_opcode, b_funct7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3, b_fmt;
    logic [63:0] b_imm;

    imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .ins(ins),
        .out_valid(a_out_valid), .out_ready(out_ready), .opcode(a_opcode), .rd(a_rd),
        .funct3(a_funct3), .rs1(a_rs1), .rs2(a_rs2), .funct7(a_funct7), .fmt(a_fmt),
        .imm(a_imm), .illegal(a_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .ins(ins),
        .out_valid(b_out_valid), .out_ready(out_ready), .opcode(b_opcode), .rd(b_rd),
        .funct3(b_funct3), .rs1(b_rs1), .rs2(b_rs2), .funct7(b_funct7), .fmt(b_fmt),
        .imm(b_imm), .illegal(b_illegal)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        fmt_e        fmt;
        logic [63:0] imm;
        logic        illegal;
    } ref_t;

    function automatic longint sext(input longint unsigned val, input int bits);
        longint unsigned half;
        half = 64'd1 << (bits - 1);
        if (val >= half) return longint'(val) - longint'(half * 64'd2);
        return longint'(val);
    endfunction

    function automatic ref_t ref_dec(input logic [31:0] w, input bit rv64);
        ref_t r;
        longint unsigned x;
        longint v;
        x = {32'b0, w};
        r.fmt = FMT_NONE;
        v = 0;
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: r.fmt = FMT_I;
                7'h1B: r.fmt = rv64 ? FMT_I : FMT_NONE;
                7'h23: r.fmt = FMT_S;
                7'h63: r.fmt = FMT_B;
                7'h37, 7'h17: r.fmt = FMT_U;
                7'h6F: r.fmt = FMT_J;
                7'h33: r.fmt = FMT_R;
                7'h3B: r.fmt = rv64 ? FMT_R : FMT_NONE;
                default: r.fmt = FMT_NONE;
            endcase
        end
        r.illegal = (r.fmt == FMT_NONE);
        case (r.fmt)
            FMT_I: v = sext(x >> 20, 12);
            FMT_S: v = sext((x >> 25) * 64'd32 + (x >> 7) % 64'd32, 12);
            FMT_B: v = sext(((x >> 31) % 64'd2) * 64'd4096 + ((x >> 7) % 64'd2) * 64'd2048
                            + ((x >> 25) % 64'd64) * 64'd32 + ((x >> 8) % 64'd16) * 64'd2, 13);
            FMT_U: v = sext((x / 64'd4096) * 64'd4096, 32);
            FMT_J: v = sext(((x >> 31) % 64'd2) * 64'd1048576 + ((x >> 12) % 64'd256) * 64'd4096
                            + ((x >> 20) % 64'd2) * 64'd2048 + ((x >> 21) % 64'd1024) * 64'd2, 21);
            default: v = 0;
        endcase
        r.imm = rv64 ? 64'(v) : {32'b0, 32'(v)};
        return r;
    endfunction

    logic [31:0] sbq[$];
    bit          alive = 1'b0;

    task automatic check_outputs();
        ref_t r32, r64;
        bit   exp_rdy;
        exp_rdy = alive && (sbq.size() < 2);
        chk("in_ready32", a_in_ready, exp_rdy);
        chk("in_ready64", b_in_ready, exp_rdy);
        chk("out_valid32", a_out_valid, sbq.size() > 0);
        chk("out_valid64", b_out_valid, sbq.size() > 0);
        if (sbq.size() > 0) begin
            r32 = ref_dec(sbq[0], 1'b0);
            r64 = ref_dec(sbq[0], 1'b1);
            chk("fields32", {a_funct7, a_rs2, a_rs1, a_funct3, a_rd, a_opcode}, sbq[0]);
            chk("fields64", {b_funct7, b_rs2, b_rs1, b_funct3, b_rd, b_opcode}, sbq[0]);
            chk("fmt32", a_fmt, r32.fmt);
            chk("fmt64", b_fmt, r64.fmt);
            chk("imm32", a_imm, r32.imm);
            chk("imm64", b_imm, r64.imm);
            chk("illegal32", a_illegal, r32.illegal);
            chk("illegal64", b_illegal, r64.illegal);
        end
    endtask

    // One clock: predict the transfers, advance, then compare.
    task automatic step(output bit acc);
        bit          a_in, a_out;
        logic [31:0] w;
        a_in  = in_valid && alive && (sbq.size() < 2);
        a_out = out_ready && (sbq.size() > 0);
        w     = ins;
        @(posedge clk);
        #1;
        if (a_out) void'(sbq.pop_front());
        if (a_in) sbq.push_back(w);
        alive = 1'b1;
        acc   = a_in;
        check_outputs();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] ins;
        fmt_e        f32;
        fmt_e        f64;
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic        ill32;
        logic        ill64;
        logic [4:0]  rd;
    } vec_t;

    vec_t vt[13];

    logic [6:0] ops[16] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0B, 7'h2A};

    initial begin
        bit          acc;
        bit          hold;
        logic [31:0] pend[$];
        logic [31:0] words[4];
        logic [31:0] got[$];

        vt[0]  = '{32'hFE208EE3, FMT_B,    FMT_B, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0, 5'd29};
        vt[1]  = '{32'hFFF00293, FMT_I,    FMT_I, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 5'd5};
        vt[2]  = '{32'h123450B7, FMT_U,    FMT_U, 64'h12345000, 64'h0000000012345000, 1'b0, 1'b0, 5'd1};
        vt[3]  = '{32'h0010006F, FMT_J,    FMT_J, 64'h00000800, 64'h0000000000000800, 1'b0, 1'b0, 5'd0};
        vt[4]  = '{32'h00000000, FMT_NONE, FMT_NONE, 64'h0, 64'h0, 1'b1, 1'b1, 5'd0};
        vt[5]  = '{32'hFFF0809B, FMT_NONE, FMT_I, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 5'd1};
        vt[6]  = '{32'hFE112C23, FMT_S,    FMT_S, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0, 5'd24};
        vt[7]  = '{32'h80000517, FMT_U,    FMT_U, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b0, 5'd10};
        vt[8]  = '{32'h002081B3, FMT_R,    FMT_R, 64'h0, 64'h0, 1'b0, 1'b0, 5'd3};
        vt[9]  = '{32'h002081BB, FMT_NONE, FMT_R, 64'h0, 64'h0, 1'b1, 1'b0, 5'd3};
        vt[10] = '{32'h00000073, FMT_I,    FMT_I, 64'h0, 64'h0, 1'b0, 1'b0, 5'd0};
        vt[11] = '{32'h00000012, FMT_NONE, FMT_NONE, 64'h0, 64'h0, 1'b1, 1'b1, 5'd0};
        vt[12] = '{32'hFFDFF0EF, FMT_J,    FMT_J, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0, 5'd1};

        // Reset state, sampled while reset is still asserted.
        #12;
        chk("rst_out_valid32", a_out_valid, 1'b0);
        chk("rst_out_valid64", b_out_valid, 1'b0);
        chk("rst_in_ready32", a_in_ready, 1'b0);
        chk("rst_fmt32", a_fmt, FMT_NONE);
        chk("rst_imm64", b_imm, 64'h0);
        chk("rst_illegal32", a_illegal, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(acc);

        // Table vectors, back-to-back with out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            ins      = vt[i].ins;
            step(acc);
            chk($sformatf("vec%0d_valid", i), a_out_valid, 1'b1);
            chk($sformatf("vec%0d_fmt32", i), a_fmt, vt[i].f32);
            chk($sformatf("vec%0d_fmt64", i), b_fmt, vt[i].f64);
            chk($sformatf("vec%0d_imm32", i), a_imm, vt[i].imm32);
            chk($sformatf("vec%0d_imm64", i), b_imm, vt[i].imm64);
            chk($sformatf("vec%0d_ill32", i), a_illegal, vt[i].ill32);
            chk($sformatf("vec%0d_ill64", i), b_illegal, vt[i].ill64);
            chk($sformatf("vec%0d_rd", i), a_rd, vt[i].rd);
            if (i == 0) begin
                chk("beq_rs1", a_rs1, 5'd1);
                chk("beq_rs2", a_rs2, 5'd2);
                chk("beq_funct3", a_funct3, 3'd0);
            end
        end
        in_valid = 1'b0;
        step(acc);

        // Skid: 4 words, 3 stalled cycles, then drain with no bubble.
        words = '{32'h00500093, 32'hFE208EE3, 32'h123450B7, 32'hFFDFF0EF};
        foreach (words[k]) pend.push_back(words[k]);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = (pend.size() > 0);
            ins      = pend[0];
            step(acc);
            if (acc) void'(pend.pop_front());
            chk($sformatf("skid_hold%0d", c), {a_funct7, a_rs2, a_rs1, a_funct3, a_rd, a_opcode}, words[0]);
            if (c >= 1) chk($sformatf("skid_full_rdy%0d", c), a_in_ready, 1'b0);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            chk($sformatf("skid_no_gap%0d", c), a_out_valid, 1'b1);
            if (a_out_valid) got.push_back({a_funct7, a_rs2, a_rs1, a_funct3, a_rd, a_opcode});
            in_valid = (pend.size() > 0);
            if (pend.size() > 0) ins = pend[0];
            step(acc);
            if (acc) void'(pend.pop_front());
        end
        chk("skid_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) chk($sformatf("skid_order%0d", k), got[k], words[k]);
        in_valid = 1'b0;
        step(acc);

        // Async reset while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ins       = 32'hFFF00293;
        step(acc);
        ins       = 32'h0010006F;
        step(acc);
        in_valid  = 1'b0;
        chk("pre_rst_full", a_in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid32", a_out_valid, 1'b0);
        chk("async_rst_valid64", b_out_valid, 1'b0);
        chk("async_rst_rdy32", a_in_ready, 1'b0);
        sbq.delete();
        alive = 1'b0;
        #1 rst = 1'b0;
        step(acc);
        chk("post_rst_rdy", a_in_ready, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        ins       = 32'hFE112C23;
        step(acc);
        chk("post_rst_valid", a_out_valid, 1'b1);
        chk("post_rst_imm32", a_imm, 32'hFFFFFFF8);
        in_valid = 1'b0;
        step(acc);

        // Randomised traffic against the model.
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                ins      = $urandom;
                if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 15)];
            end
            out_ready = ($urandom_range(0, 2) != 0);
            step(acc);
            hold = in_valid && !acc;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
